// File: rtl/spike_arbiter.sv
// spike_arbiter: latches per-source spike pulses into pending flags and
// grants one pending source per cycle, round-robin, onto a registered
// valid/ready output feeding the axon interface (spike_in / source_id).
// Collisions with a still-pending source are dropped and counted.
module spike_arbiter #(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [NUM_SRC-1:0]    spike_req,
  input  logic                  out_ready,
  output logic                  out_spike,
  output logic [ADDR_WIDTH-1:0] out_source_id,
  output logic [NUM_SRC-1:0]    pending,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  localparam int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned SCAN_W  = PTR_W + 1;
  localparam int unsigned POP_W   = $clog2(NUM_SRC + 1);
  localparam int unsigned SUM_W   = POP_W + 9;
  localparam int unsigned CNT_MAX = 255;

  logic [NUM_SRC-1:0]    pending_q, pending_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  out_spike_q, out_spike_d;
  logic [ADDR_WIDTH-1:0] out_source_id_q, out_source_id_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic                  free_c;
  logic                  grant_c;
  logic                  gnt_found;
  logic [PTR_W-1:0]      gnt_idx;
  logic [SCAN_W-1:0]     scan_idx;
  logic [NUM_SRC-1:0]    gnt_vec;
  logic [NUM_SRC-1:0]    drop_vec;
  logic [POP_W-1:0]      drop_pop;
  logic [SUM_W-1:0]      drop_sum;

  // First pending source at or above rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_idx = SCAN_W'(rr_ptr_q) + SCAN_W'(k);
      if (scan_idx >= SCAN_W'(NUM_SRC)) begin
        scan_idx = scan_idx - SCAN_W'(NUM_SRC);
      end
      if (!gnt_found && pending_q[PTR_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(scan_idx);
      end
    end
  end

  assign free_c  = !out_spike_q || out_ready;
  assign grant_c = enable && free_c && gnt_found && !flush;

  // One-hot of the source being granted this cycle (zero when no grant).
  always_comb begin
    gnt_vec = '0;
    if (grant_c) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // Pending flags and drop accounting; flush discards everything incoming.
  always_comb begin
    pending_d = '0;
    drop_vec  = '0;
    drop_pop  = '0;
    if (!flush) begin
      pending_d = (pending_q & ~gnt_vec) | spike_req;
      drop_vec  = spike_req & pending_q & ~gnt_vec;
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drop_pop = drop_pop + POP_W'(drop_vec[i]);
    end
    drop_sum     = SUM_W'(drop_count_q) + SUM_W'(drop_pop);
    drop_count_d = (drop_sum > SUM_W'(CNT_MAX)) ? 8'hFF : drop_sum[7:0];
  end

  // Output stage and round-robin pointer; output holds under backpressure.
  always_comb begin
    out_spike_d     = out_spike_q;
    out_source_id_d = out_source_id_q;
    rr_ptr_d        = rr_ptr_q;
    if (flush) begin
      out_spike_d = 1'b0;
    end else if (grant_c) begin
      out_spike_d     = 1'b1;
      out_source_id_d = ADDR_WIDTH'(gnt_idx);
      rr_ptr_d        = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else if (free_c) begin
      out_spike_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q       <= '0;
      rr_ptr_q        <= '0;
      out_spike_q     <= 1'b0;
      out_source_id_q <= '0;
      drop_count_q    <= '0;
    end else begin
      pending_q       <= pending_d;
      rr_ptr_q        <= rr_ptr_d;
      out_spike_q     <= out_spike_d;
      out_source_id_q <= out_source_id_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign out_spike     = out_spike_q;
  assign out_source_id = out_source_id_q;
  assign pending       = pending_q;
  assign drop_count    = drop_count_q;
  assign busy          = (|pending_q) || out_spike_q;

endmodule

// File: tb/tb_spike_arbiter.sv
// tb_spike_arbiter: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter.
module tb_spike_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  spike_req = '0;
  logic          out_ready = 1'b0;
  logic          out_spike;
  logic [AW-1:0] out_source_id;
  logic [N-1:0]  pending;
  logic [7:0]    drop_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [N-1:0] m_pend;
  int           m_ptr;
  bit           m_ov;
  int           m_oid;
  int           m_drop;

  spike_arbiter #(.NUM_SRC(N), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .spike_req    (spike_req),
    .out_ready    (out_ready),
    .out_spike    (out_spike),
    .out_source_id(out_source_id),
    .pending      (pending),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_ov = 0; m_oid = 0; m_drop = 0;
  endtask

  task automatic check_model();
    check("pending", 32'(pending), 32'(m_pend));
    check("out_spike", 32'(out_spike), 32'(m_ov));
    check("out_source_id", 32'(out_source_id), 32'(m_oid));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("busy", 32'(busy), 32'((m_pend != 0) || m_ov));
  endtask

  // One clock: model the edge from current inputs, then compare after it.
  task automatic step();
    int g, nptr, noid, ndrop;
    bit gr, fr, nov, hit;
    logic [N-1:0] np;
    fr = !m_ov || out_ready;
    g  = -1;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (g < 0 && m_pend[idx]) g = idx;
    end
    gr    = enable && fr && (g >= 0) && !flush;
    np    = '0;
    ndrop = m_drop;
    if (!flush) begin
      for (int i = 0; i < int'(N); i++) begin
        hit = gr && (g == i);
        if (spike_req[i] && m_pend[i] && !hit && ndrop < 255) ndrop++;
        np[i] = (m_pend[i] && !hit) || spike_req[i];
      end
    end
    nov = m_ov; noid = m_oid; nptr = m_ptr;
    if (flush) nov = 0;
    else if (gr) begin nov = 1; noid = g; nptr = (g + 1) % int'(N); end
    else if (fr) nov = 0;
    @(posedge clk);
    #1;
    m_pend = np; m_ov = nov; m_oid = noid; m_ptr = nptr; m_drop = ndrop;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    spike_req = '0; flush = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #2;
    model_reset();
    check("rst_out_spike", 32'(out_spike), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single spike on source 2
    enable = 1; out_ready = 1;
    spike_req = 8'h04; step();
    check("single_pend", 32'(pending), 32'h04);
    spike_req = '0; step();
    check("single_valid", 32'(out_spike), 32'h1);
    check("single_id", 32'(out_source_id), 32'h2);
    step();
    check("single_drain", 32'(out_spike), 32'h0);

    // All sources at once: IDs 0..7 back to back
    do_reset();
    spike_req = 8'hFF; step();
    spike_req = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("all_id", 32'(out_source_id), 32'(i));
      check("all_valid", 32'(out_spike), 32'h1);
    end
    step();
    check("all_drop", 32'(drop_count), 32'h0);
    check("all_idle", 32'(busy), 32'h0);

    // Fairness: sources 1 and 6 re-requesting every cycle
    do_reset();
    spike_req = 8'h42; step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("fair_id", 32'(out_source_id), (i % 2 == 0) ? 32'd1 : 32'd6);
    end
    spike_req = '0;

    // Backpressure: source 3 held while out_ready low, then source 5
    do_reset();
    out_ready = 0;
    spike_req = 8'h28; step();
    spike_req = '0; step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(out_spike), 32'h1);
      check("bp_id", 32'(out_source_id), 32'h3);
    end
    out_ready = 1; step();
    check("bp_next_id", 32'(out_source_id), 32'h5);
    check("bp_next_valid", 32'(out_spike), 32'h1);

    // Drops with enable low, then saturation
    do_reset();
    enable = 0;
    spike_req = 8'h20; step(); step();
    check("drop_one", 32'(drop_count), 32'd1);
    for (int i = 0; i < 300; i++) step();
    check("drop_sat", 32'(drop_count), 32'd255);
    spike_req = '0;

    // Same-cycle request and grant, then flush with all requests
    do_reset();
    enable = 1; out_ready = 1;
    spike_req = 8'h01; step();
    step();
    check("same_pend", 32'(pending), 32'h01);
    check("same_drop", 32'(drop_count), 32'h0);
    check("same_id", 32'(out_source_id), 32'h0);
    flush = 1; spike_req = 8'hFF; step();
    check("flush_pend", 32'(pending), 32'h0);
    check("flush_valid", 32'(out_spike), 32'h0);
    check("flush_drop", 32'(drop_count), 32'h0);
    flush = 0; spike_req = '0;

    // Randomized traffic with occasional mid-run async reset
    for (int c = 0; c < 3000; c++) begin
      spike_req = N'($urandom & $urandom);
      enable    = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(15, 0) == 0);
      step();
      if ($urandom_range(199, 0) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_pending", 32'(pending), 32'h0);
        check("midrst_valid", 32'(out_spike), 32'h0);
        check("midrst_drop", 32'(drop_count), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        #1;
        rst = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_arbiter.md
# spike_arbiter

Round-robin arbiter that shares the single axon routing interface among `NUM_SRC` neuron spike sources. Each source's spike pulse is latched into a pending flag. One pending spike per cycle is granted onto a registered valid/ready output that drives the axon interface's `spike_in`/`source_id`. Spikes that arrive while the same source is still pending are dropped and counted.

## Interface
- `NUM_SRC`, 8, number of spike sources; 2 ≤ `NUM_SRC` ≤ 2^`ADDR_WIDTH`
- `ADDR_WIDTH`, 4, width of the source ID driven to the axon interface
- `clk` input 1 system clock, rising edge
- `rst` input 1 reset, asynchronous, active-low
- `enable` input 1 grant enable; when low, spikes still latch but no new grants are made
- `flush` input 1 synchronous clear of pending flags and the output stage
- `spike_req` input `NUM_SRC` one-cycle spike pulses, one bit per source
- `out_ready` input 1 downstream accepts `out_spike` this cycle; tie high for the axon interface
- `out_spike` output 1 registered spike valid, connects to `spike_in`
- `out_source_id` output `ADDR_WIDTH` registered granted source index, connects to `source_id`
- `pending` output `NUM_SRC` current pending flags
- `drop_count` output 8 saturating count of dropped spikes
- `busy` output 1 high when `pending` is nonzero or `out_spike` is high

## Operation
- State:
  - `pending[NUM_SRC-1:0]`
  - round-robin pointer `rr_ptr` (0..NUM_SRC-1)
  - output register (`out_spike`, `out_source_id`)
  - `drop_count`
- Output stage "free" = !`out_spike` || `out_ready`.
- Grant condition: `enable` && free && |`pending` && !`flush`.
- Grant selection: the first set bit of `pending` scanning from index `rr_ptr` upward, wrapping modulo `NUM_SRC`; granted index = g.
- On grant:
  - `out_spike` ← 1
  - `out_source_id` ← g, zero-extended to `ADDR_WIDTH`
  - `pending[g]` cleared
  - `rr_ptr` ← (g+1) mod `NUM_SRC`; wraps from `NUM_SRC`-1 to 0
- Free with no grant: `out_spike` ← 0 and `out_source_id` holds. Not free: both hold.
- Pending update per bit i:
  - next = (`pending[i]` && !(granted i)) || `spike_req[i]`
  - A request arriving in the same cycle its bit is granted re-sets the bit and is not a drop.
- Drop: `spike_req[i]` && `pending[i]` && !(granted i). Each dropped bit adds 1 to `drop_count` (multiple drops in one cycle add their popcount), saturating at 255.
- `flush`:
  - next `pending` = 0, `out_spike` = 0, no grant
  - `spike_req` in the flush cycle is discarded and not counted as a drop
  - `rr_ptr` and `drop_count` hold
- `enable` low: pending keeps accumulating and drops keep counting. The output stage still drains: `out_spike` clears once `out_ready` is seen.
- No FSM beyond the output-valid bit; all decisions come from registered state plus the current inputs.

## Timing
- Reset (`rst`=0, async):
  - `pending`=0, `out_spike`=0, `out_source_id`=0, `rr_ptr`=0, `drop_count`=0
  - `busy`=0 (combinational from reset state)
- Latency: `spike_req[i]` sampled at edge E0 sets `pending[i]` after E0. The earliest grant is at E1, with `out_spike`=1 after E1. The axon interface registers it at E2.
- Throughput: one grant per cycle while `out_ready`=1 and pending is nonzero.
- Handshake: `out_spike`/`out_source_id` are stable while `out_spike`=1 && `out_ready`=0.
- Reset asserted mid-operation clears all state immediately. Any spike in flight is lost and is not counted.
- `busy` and `pending` are combinational from registers only and have no input-to-output paths.

## Test plan
- Reset then single spike: `spike_req`=8'h04 for one cycle -> `pending`=8'h04 next cycle; `out_spike`=1 with `out_source_id`=2 one cycle later, then `out_spike`=0.
- All sources at once: `spike_req`=8'hFF for one cycle, `out_ready`=1 -> IDs 0,1,…,7 on consecutive cycles, `rr_ptr` wraps to 0, `drop_count`=0.
- Fairness: keep sources 1 and 6 re-requesting every cycle -> grants alternate 1,6,1,6, with no starvation.
- Backpressure: grant source 3 with `out_ready`=0 for 4 cycles -> `out_spike`=1 and `out_source_id`=3 held. Raise `out_ready` -> next pending source granted the following cycle.
- Drops: `spike_req[5]` twice while `enable`=0 -> `drop_count`=1. Drive 300 further collisions -> `drop_count` saturates at 255.
- Same-cycle request and grant, plus flush: request source 0 in the cycle it is granted -> `pending[0]`=1 again and no drop. Then assert `flush` with `spike_req`=8'hFF -> `pending`=0, `out_spike`=0, `drop_count` unchanged.
